// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
// Decodes the ID/EX instruction, computes ALU results into the EX/WB
// register, resolves BEQ/JMP for ctrl, and (with EX_MUL_EN defined) runs a
// 16-cycle shift-add multiplier that stalls upstream while busy.
// Without EX_MUL_EN, opcode 0101 decodes as NOP and stall_o is tied to 0.
module ex_stage #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   inst_i,
    input  logic [AW-1:0] inst_addr_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [RW-1:0] rd_addr_i,
    input  logic          reg_wen_i,
    output logic [RW-1:0] rd_addr_o,
    output logic [DW-1:0] rd_data_o,
    output logic          reg_wen_o,
    output logic          jump_en_o,
    output logic [AW-1:0] jump_addr_o,
    output logic          stall_o
);

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;

    typedef struct packed {
        logic [RW-1:0] rd_addr;
        logic [DW-1:0] rd_data;
        logic          wen;
    } wb_t;

    logic [3:0] opcode;
    wb_t        alu_wb;
    wb_t        wb_q;
    logic       fsm_idle;

    assign opcode = inst_i[15:12];

    // ALU result and writeback controls; non-ALU opcodes yield an all-zero bundle
    always_comb begin
        alu_wb = '0;
        case (opcode)
            OP_ADD: alu_wb = '{rd_addr: rd_addr_i, rd_data: op1_i + op2_i, wen: reg_wen_i};
            OP_SUB: alu_wb = '{rd_addr: rd_addr_i, rd_data: op1_i - op2_i, wen: reg_wen_i};
            OP_AND: alu_wb = '{rd_addr: rd_addr_i, rd_data: op1_i & op2_i, wen: reg_wen_i};
            OP_OR:  alu_wb = '{rd_addr: rd_addr_i, rd_data: op1_i | op2_i, wen: reg_wen_i};
            default: alu_wb = '0;
        endcase
    end

`ifdef EX_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

    mul_state_t    state;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;
    logic [3:0]    cnt;
    logic [RW-1:0] mul_rd;
    logic          mul_wen;
    logic          is_mul;

    assign is_mul   = (opcode == OP_MUL);
    assign fsm_idle = (state == IDLE);
    assign stall_o  = (fsm_idle && is_mul) || (state == BUSY);

    // Multiply sequencer: one shift-add step per BUSY cycle, 16 steps total
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            mul_rd  <= '0;
            mul_wen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        state   <= BUSY;
                        mcand   <= op1_i;
                        mplier  <= op2_i;
                        acc     <= '0;
                        cnt     <= '0;
                        mul_rd  <= rd_addr_i;
                        mul_wen <= reg_wen_i;
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // EX/WB register: product on DONE, ALU result in IDLE, hold while multiplying
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q <= '0;
        end else if (state == DONE) begin
            wb_q <= '{rd_addr: mul_rd, rd_data: acc, wen: mul_wen};
        end else if (fsm_idle && !is_mul) begin
            wb_q <= alu_wb;
        end
    end
`else
    assign fsm_idle = 1'b1;
    assign stall_o  = 1'b0;

    // EX/WB register: ALU result every cycle, zero for non-ALU opcodes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wb_q <= '0;
        else      wb_q <= alu_wb;
    end
`endif

    assign rd_addr_o = wb_q.rd_addr;
    assign rd_data_o = wb_q.rd_data;
    assign reg_wen_o = wb_q.wen;

    // Branch resolution; suppressed in reset and while a multiply is in flight
    always_comb begin
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        if (rst && fsm_idle &&
            ((opcode == OP_JMP) || ((opcode == OP_BEQ) && (op1_i == op2_i)))) begin
            jump_en_o   = 1'b1;
            jump_addr_o = inst_i[AW-1:0];
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage (both EX_MUL_EN builds).
module tb_ex_stage;

    localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, AND = 4'h3;
    localparam logic [3:0] OR  = 4'h4, MUL = 4'h5, BEQ = 4'h6, JMP = 4'h7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] inst_i = '0;
    logic [3:0]  inst_addr_i = '0;
    logic [15:0] op1_i = '0, op2_i = '0;
    logic [2:0]  rd_addr_i = '0;
    logic        reg_wen_i = 1'b0;
    logic [2:0]  rd_addr_o;
    logic [15:0] rd_data_o;
    logic        reg_wen_o;
    logic        jump_en_o;
    logic [3:0]  jump_addr_o;
    logic        stall_o;

    int n_chk = 0;
    int n_err = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i), .reg_wen_i(reg_wen_i),
        .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_wen_o(reg_wen_o),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] rd, input logic wen, input logic [3:0] lo);
        inst_i    = {op, 8'h00, lo};
        op1_i     = a;
        op2_i     = b;
        rd_addr_i = rd;
        reg_wen_i = wen;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic [2:0] rd, input logic [15:0] d, input logic w);
        check({tag, "_rd"},  {29'd0, rd_addr_o}, {29'd0, rd});
        check({tag, "_dat"}, {16'd0, rd_data_o}, {16'd0, d});
        check({tag, "_wen"}, {31'd0, reg_wen_o}, {31'd0, w});
    endtask

`ifdef EX_MUL_EN
    // Hold MUL while stalled, let ctrl advance to NOP on the DONE edge
    task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] rd, input logic [15:0] exp);
        int n;
        drive(MUL, a, b, rd, 1'b1, 4'h0);
        #1;
        n = 0;
        while (stall_o && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, n, 17);
        drive(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0);
        tick();
        chk_wb(tag, rd, exp, 1'b1);
    endtask
`endif

    initial begin
        // reset with random operands and a JMP on the bus
        drive(JMP, 16'($urandom), 16'($urandom), 3'($urandom), 1'b1, 4'($urandom));
        repeat (3) tick();
        chk_wb("rst", 3'd0, 16'h0, 1'b0);
        check("rst_jen",   {31'd0, jump_en_o}, 32'd0);
        check("rst_jaddr", {28'd0, jump_addr_o}, 32'd0);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        drive(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0);
        rst = 1'b1;
        tick();

        // ALU ops, 1-cycle latency
        drive(ADD, 16'hFFFF, 16'h0002, 3'd3, 1'b1, 4'h0); tick(); chk_wb("add", 3'd3, 16'h0001, 1'b1);
        drive(SUB, 16'h0000, 16'h0001, 3'd1, 1'b1, 4'h0); tick(); chk_wb("sub", 3'd1, 16'hFFFF, 1'b1);
        drive(AND, 16'hF0F0, 16'h3C3C, 3'd2, 1'b1, 4'h0); tick(); chk_wb("and", 3'd2, 16'h3030, 1'b1);
        drive(OR,  16'hF0F0, 16'h0F00, 3'd7, 1'b1, 4'h0); tick(); chk_wb("or",  3'd7, 16'hFFF0, 1'b1);
        drive(ADD, 16'h0010, 16'h0020, 3'd4, 1'b0, 4'h0); tick(); chk_wb("add_nw", 3'd4, 16'h0030, 1'b0);
        drive(OR,  16'h1200, 16'h0034, 3'd6, 1'b0, 4'h0); tick(); chk_wb("or_nw",  3'd6, 16'h1234, 1'b0);

        // jumps: combinational in the same cycle, EX/WB cleared next cycle
        drive(ADD, 16'h0001, 16'h0001, 3'd5, 1'b1, 4'h0); tick();
        drive(BEQ, 16'h1234, 16'h1234, 3'd5, 1'b1, 4'hA); #1;
        check("beq_jen",   {31'd0, jump_en_o}, 32'd1);
        check("beq_jaddr", {28'd0, jump_addr_o}, 32'hA);
        tick(); chk_wb("beq_wb", 3'd0, 16'h0, 1'b0);
        drive(BEQ, 16'h1234, 16'h1235, 3'd5, 1'b1, 4'hA); #1;
        check("bne_jen",   {31'd0, jump_en_o}, 32'd0);
        check("bne_jaddr", {28'd0, jump_addr_o}, 32'd0);
        tick();
        drive(JMP, 16'h0, 16'h0, 3'd2, 1'b1, 4'h5); #1;
        check("jmp_jen",   {31'd0, jump_en_o}, 32'd1);
        check("jmp_jaddr", {28'd0, jump_addr_o}, 32'h5);
        tick(); chk_wb("jmp_wb", 3'd0, 16'h0, 1'b0);
        drive(ADD, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0); #1;
        check("add_jen", {31'd0, jump_en_o}, 32'd0);
        tick();

`ifdef EX_MUL_EN
        do_mul("mul1", 16'h0123, 16'h0045, 3'd5, 16'h4E6F);
        do_mul("mul2", 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001);

        // reset mid-multiply
        drive(MUL, 16'h0123, 16'h0045, 3'd6, 1'b1, 4'h0);
        repeat (9) tick();
        check("busy_stall", {31'd0, stall_o}, 32'd1);
        rst = 1'b0;
        drive(NOP, 16'h0, 16'h0, 3'd0, 1'b0, 4'h0);
        #1;
        check("mrst_stall", {31'd0, stall_o}, 32'd0);
        check("mrst_jen",   {31'd0, jump_en_o}, 32'd0);
        chk_wb("mrst", 3'd0, 16'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        do_mul("mul3", 16'h0002, 16'h0003, 3'd1, 16'h0006);
`else
        drive(ADD, 16'h0002, 16'h0003, 3'd1, 1'b1, 4'h0); tick();
        chk_wb("pre_mul", 3'd1, 16'h0005, 1'b1);
        drive(MUL, 16'h0002, 16'h0003, 3'd1, 1'b1, 4'h0); #1;
        check("nomul_stall0", {31'd0, stall_o}, 32'd0);
        tick();
        check("nomul_stall1", {31'd0, stall_o}, 32'd0);
        chk_wb("nomul", 3'd0, 16'h0, 1'b0);
        tick();
        check("nomul_stall2", {31'd0, stall_o}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit pipeline, sitting on the consumer side of the ID/EX register. It decodes the registered instruction and operands and computes ALU results into a registered EX/WB output. It resolves branches and jumps, returning the jump request and target to ctrl, which flushes upstream. It also runs an iterative 16-cycle shift-add multiplier and raises a stall request to ctrl while the multiply is busy.

## Interface
Parameters:
- DW, 16, datapath width (op1/op2/result)
- AW, 4, instruction address width
- RW, 3, register address width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- inst_i  input  16  instruction from ID/EX
- inst_addr_i  input  AW  address of inst_i
- op1_i  input  DW  first operand
- op2_i  input  DW  second operand
- rd_addr_i  input  RW  destination register
- reg_wen_i  input  1  destination write enable from decode
- rd_addr_o  output  RW  registered writeback address
- rd_data_o  output  DW  registered writeback data
- reg_wen_o  output  1  registered writeback enable
- jump_en_o  output  1  combinational jump request to ctrl
- jump_addr_o  output  AW  combinational jump target
- stall_o  output  1  combinational stall request to ctrl (hold PC, IF/ID, ID/EX)

## Operation
- Opcode is inst_i[15:12]:
  - 0000 NOP
  - 0001 ADD
  - 0010 SUB
  - 0011 AND
  - 0100 OR
  - 0101 MUL
  - 0110 BEQ
  - 0111 JMP
  - all others behave as NOP
- ADD/SUB: arithmetic is modulo 2^16; no carry or overflow output.
- ALU ops (ADD/SUB/AND/OR): at the clock edge, rd_data_o gets the result, rd_addr_o gets rd_addr_i, and reg_wen_o gets reg_wen_i.
- NOP, BEQ, JMP, undefined opcodes: at the clock edge, reg_wen_o←0; rd_addr_o and rd_data_o are cleared to 0.
- JMP: jump_en_o=1 and jump_addr_o=inst_i[3:0].
- BEQ: jump_en_o=(op1_i==op2_i) and jump_addr_o=inst_i[3:0].
- When jump_en_o=0, jump_addr_o=0.
- jump_en_o is forced to 0 whenever the FSM is not IDLE.
- MUL FSM states are IDLE, BUSY, DONE:
  - IDLE → BUSY when the opcode is MUL. The edge loads the multiplicand (op1_i), the multiplier (op2_i) and the latched rd_addr_i/reg_wen_i; it clears the accumulator and the 4-bit counter.
  - BUSY: once per cycle, if multiplier[0], acc←acc+multiplicand. Then multiplicand←multiplicand<<1, multiplier←multiplier>>1, cnt←cnt+1. When cnt==15, go to DONE.
  - DONE → IDLE unconditionally. At this edge the EX/WB outputs load acc (the low 16 bits of the product), the latched rd_addr and the latched reg_wen.
- stall_o = (IDLE and opcode==MUL) or BUSY. It is 0 in DONE, so upstream advances on the same edge the product is written.
- While stall_o=1, ctrl freezes ID/EX, so inst_i stays MUL. The EX/WB outputs hold their previous values during IDLE-with-MUL and BUSY cycles.
- In DONE, inst_i still shows MUL. This does not restart the multiply, because the FSM leaves DONE to IDLE.
- Reset (rst=0), at any time including mid-multiply:
  - FSM goes to IDLE; counter and datapath registers clear.
  - rd_addr_o=0, rd_data_o=0, reg_wen_o=0.
  - jump_en_o=0, jump_addr_o=0.
  - stall_o=0, provided inst_i=NOP (ID/EX resets to NOP).

## Timing
- ALU op presented in cycle n: result is visible on the EX/WB outputs in cycle n+1 (1-cycle latency).
- Jump: jump_en_o is asserted within cycle n, so ctrl flushes ID/EX at the end of cycle n.
- MUL presented in cycle n:
  - stall_o is high for cycles n through n+16 (17 cycles).
  - DONE occurs in cycle n+17.
  - The product is visible on the EX/WB outputs in cycle n+18.
- Back-to-back MULs: the second one is seen in IDLE in cycle n+18 and starts immediately.

## Configuration
- Macro: EX_MUL_EN.
- Defined: MUL is handled as described above.
- Undefined:
  - No FSM, multiplier or counter is built.
  - opcode 0101 decodes as NOP and writes nothing.
  - stall_o is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs 0. Release rst, send ADD op1=0xFFFF op2=0x0002 rd=3 wen=1 → next cycle rd_data_o=0x0001, rd_addr_o=3, reg_wen_o=1.
- SUB op1=0x0000 op2=0x0001 → 0xFFFF. AND 0xF0F0 & 0x3C3C → 0x3030. OR 0xF0F0 | 0x0F00 → 0xFFF0. Same ops with reg_wen_i=0 → reg_wen_o=0.
- Jumps:
  - BEQ op1=op2=0x1234, inst[3:0]=0xA → jump_en_o=1, jump_addr_o=0xA in the same cycle, reg_wen_o=0 next cycle.
  - BEQ op1=0x1234 op2=0x1235 → jump_en_o=0.
  - JMP inst[3:0]=0x5 → jump_en_o=1, jump_addr_o=0x5.
- MUL 0x0123×0x0045 rd=5 wen=1, with inst held while stall_o=1:
  - stall_o is high for exactly 17 cycles.
  - Result is 0x4E6F on rd 5, one cycle after DONE.
  - Also check 0xFFFF×0xFFFF → 0x0001.
- Assert rst=0 at BUSY cycle 8 → stall_o=0 and all outputs 0. After release, a new MUL 0x0002×0x0003 → 0x0006.
- Build without EX_MUL_EN: MUL 0x0002×0x0003 → stall_o never asserts and reg_wen_o=0 next cycle.
